// File: rtl/nbin_sequencer.sv
// -----------------------------------------------------------------------------
// nbin_sequencer
//   Programmable 4-bit binary code sequencer feeding the Gray encoder's NBin
//   input. Steps from a captured first code to a captured last code, counting
//   up or down modulo 16. Each code is held dwell+1 cycles. Runs either as a
//   single pass (ends with a done pulse) or continuously (restarts at first
//   with a wrap pulse). Start/stop control; every output is registered.
//
// Parameters
//   DW          width of the dwell counter / dwell input
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high, overrides everything
//   start       begin a sequence (accepted in IDLE only, and only when stop=0)
//   stop        abort a running sequence (no done/wrap pulse)
//   dir         0 = count up, 1 = count down        (captured at start)
//   mode        0 = continuous, 1 = single pass     (captured at start)
//   dwell       extra hold cycles per code          (captured at start)
//   first       first code of the sequence          (captured at start)
//   last        final code of the sequence          (captured at start)
//   NBin        registered binary code to the Gray encoder
//   nbin_valid  NBin carries a live sequence code
//   busy        sequencer is in RUN
//   done        one-cycle pulse: single pass completed
//   wrap        one-cycle pulse: continuous pass restarted at first
// -----------------------------------------------------------------------------
module nbin_sequencer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          dir,
  input  logic          mode,
  input  logic [DW-1:0] dwell,
  input  logic [3:0]    first,
  input  logic [3:0]    last,
  output logic [3:0]    NBin,
  output logic          nbin_valid,
  output logic          busy,
  output logic          done,
  output logic          wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    nbin_q, nbin_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          wrap_q, wrap_d;

  // Configuration captured on an accepted start.
  logic          dir_q, dir_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    first_q, first_d;
  logic [3:0]    last_q, last_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d = state_q;
    nbin_d  = nbin_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    dir_d   = dir_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    first_d = first_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          nbin_d  = first;
          cnt_d   = dwell;
          dir_d   = dir;
          mode_d  = mode;
          dwell_d = dwell;
          first_d = first;
          last_d  = last;
        end
      end

      RUN: begin
        // stop wins over a coincident step; NBin keeps the current code.
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (nbin_q != last_q) begin
          // 4-bit arithmetic gives the modulo-16 wrap for free.
          nbin_d = dir_q ? (nbin_q - 4'd1) : (nbin_q + 4'd1);
          cnt_d  = dwell_q;
        end else if (mode_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          nbin_d = first_q;
          wrap_d = 1'b1;
          cnt_d  = dwell_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops see pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      nbin_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      dwell_q <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      nbin_q  <= nbin_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // valid and busy both mean "in RUN"; they come straight from the state flop.
  assign NBin       = nbin_q;
  assign nbin_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_nbin_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nbin_sequencer
//   Directed self-checking bench for nbin_sequencer. Inputs change just after
//   the falling edge; outputs are sampled on the following falling edge.
//   Each comparison checks the packed vector {NBin, valid, busy, done, wrap}.
// -----------------------------------------------------------------------------
module tb_nbin_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          dir;
  logic          mode;
  logic [DW-1:0] dwell;
  logic [3:0]    first;
  logic [3:0]    last;
  logic [3:0]    NBin;
  logic          nbin_valid;
  logic          busy;
  logic          done;
  logic          wrap;

  int checks   = 0;
  int failures = 0;

  nbin_sequencer #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .mode       (mode),
    .dwell      (dwell),
    .first      (first),
    .last       (last),
    .NBin       (NBin),
    .nbin_valid (nbin_valid),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  // One clock: rising edge applies inputs, falling edge is the sample point.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] e_nbin,
                       input logic e_valid, input logic e_busy,
                       input logic e_done, input logic e_wrap);
    logic [7:0] observed;
    logic [7:0] expected;
    observed = {NBin, nbin_valid, busy, done, wrap};
    expected = {e_nbin, e_valid, e_busy, e_done, e_wrap};
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s: got nbin/valid/busy/done/wrap=%h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
               tag, observed[7:4], observed[3], observed[2], observed[1], observed[0],
               expected[7:4], expected[3], expected[2], expected[1], expected[0]);
      end
  endtask

  initial begin
    logic [3:0] down_seq [4];
    logic [3:0] cont_seq [7];
    down_seq = '{4'd1, 4'd0, 4'd15, 4'd14};
    cont_seq = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15, 4'd0};

    // Reset held two cycles with start asserted: start must not win.
    rst = 1'b1; start = 1'b1; stop = 1'b0; dir = 1'b0; mode = 1'b1;
    dwell = 8'd0; first = 4'd5; last = 4'd7;
    @(negedge clk);
    tick();
    tick();
    check("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Up, single pass, dwell 0; config changes after start must be ignored.
    first = 4'd3; last = 4'd6; dwell = 8'd0; dir = 1'b0; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; first = 4'd0; last = 4'd0; dir = 1'b1; mode = 1'b0; dwell = 8'd5;
    check("up_3", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check("up_4", 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check("up_5", 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check("up_6", 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check("up_done", 4'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); check("up_after_done", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);

    // Down through 0 -> 15, dwell 2: 4 codes x 3 cycles, then done.
    first = 4'd1; last = 4'd14; dwell = 8'd2; dir = 1'b1; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (i != 0 || j != 0) tick();
        check($sformatf("down_code%0d_cyc%0d", i, j), down_seq[i], 1'b1, 1'b1, 1'b0, 1'b0);
      end
    end
    tick(); check("down_done", 4'd14, 1'b0, 1'b0, 1'b1, 1'b0);

    // Continuous one-code sequence, dwell 1: wrap every second cycle.
    first = 4'd9; last = 4'd9; dwell = 8'd1; dir = 1'b0; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("cont9_c1", 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check("cont9_c2", 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check("cont9_c3_wrap", 4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); check("cont9_c4", 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    // Counter is 0 here, so a step is due; stop must beat it (no wrap).
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("cont9_stop", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);

    // start & stop together in IDLE: stay IDLE.
    first = 4'd2; last = 4'd5; dwell = 8'd0; dir = 1'b0; mode = 1'b1;
    start = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("start_stop_idle", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    // Now a clean start.
    tick();
    start = 1'b0;
    check("run_2", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    // start in RUN with a new first: ignored.
    start = 1'b1; first = 4'd10;
    tick();
    start = 1'b0;
    check("start_in_run_ignored", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check("run_4", 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    // Reset mid-run: reset values, no done.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_run", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check("rst_mid_run_after", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stop while IDLE has no effect.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_in_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous up across 15 -> 0, restart at 14 with wrap.
    first = 4'd14; last = 4'd1; dwell = 8'd0; dir = 1'b0; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i != 0) tick();
      check($sformatf("cont_up_%0d", i), cont_seq[i], 1'b1, 1'b1, 1'b0, (i == 4) ? 1'b1 : 1'b0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("cont_up_stop", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
